fwd_scoreboard: RTL and testbench

- Parametrised successor to the EX-stage forwarding logic.
- Tracks every in-flight register write whose result arrives after a variable latency (ALU, load, multi-cycle divide) using a per-register countdown scoreboard.
- Drives forward-enable and forward-data for NREAD source operands, and raises a stall when an operand's producer has not yet delivered.
- Sits between decode/issue and EX; results arrive on a completion bus and a writeback bus.

---
 rtl/fwd_scoreboard_if.sv | 41 ++++
 rtl/fwd_scoreboard.sv | 81 ++++++++
 tb/tb_fwd_scoreboard.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_scoreboard_if.sv
// Bus bundle between decode/issue, the result buses and the forwarding scoreboard.
// master = issue/result side, slave = scoreboard.
interface fwd_scoreboard_if #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int NREAD  = 2,
   parameter int MAXLAT = 7
);
   localparam int RW = $clog2(NREG);
   localparam int CW = $clog2(MAXLAT + 1);

   logic                    flush;
   logic                    issue_valid;
   logic                    issue_wr;
   logic [RW-1:0]           issue_rd;
   logic [CW-1:0]           issue_lat;
   logic [NREAD*RW-1:0]     rs_addr;
   logic [NREAD-1:0]        rs_valid;
   logic                    res_valid;
   logic [RW-1:0]           res_rd;
   logic [XLEN-1:0]         res_data;
   logic                    wb_valid;
   logic [RW-1:0]           wb_rd;
   logic [XLEN-1:0]         wb_data;
   logic                    stall;
   logic [NREAD-1:0]        fwd_en;
   logic [NREAD*XLEN-1:0]   fwd_data;
   logic [31:0]             stall_cycles;

   modport master (
      output flush, issue_valid, issue_wr, issue_rd, issue_lat, rs_addr, rs_valid,
             res_valid, res_rd, res_data, wb_valid, wb_rd, wb_data,
      input  stall, fwd_en, fwd_data, stall_cycles
   );

   modport slave (
      input  flush, issue_valid, issue_wr, issue_rd, issue_lat, rs_addr, rs_valid,
             res_valid, res_rd, res_data, wb_valid, wb_rd, wb_data,
      output stall, fwd_en, fwd_data, stall_cycles
   );
endinterface

// File: rtl/fwd_scoreboard.sv
// EX-stage forwarding with a per-register countdown scoreboard for variable-latency producers.
// Forwards from completion/writeback buses and stalls issue on RAW or WAW hazards.
module fwd_scoreboard #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int NREAD  = 2,
   parameter int MAXLAT = 7
) (
   input  logic             clk,
   input  logic             rst,
   fwd_scoreboard_if.slave  sb
);
   localparam int RW = $clog2(NREG);
   localparam int CW = $clog2(MAXLAT + 1);

   logic [CW-1:0]         cnt [NREG];
   logic [CW-1:0]         lat_eff;
   logic [RW-1:0]         rs;
   logic                  waw;
   logic                  opnd_haz;
   logic                  stall;
   logic                  fire;
   logic [NREAD-1:0]      fwd_en;
   logic [NREAD*XLEN-1:0] fwd_data;
   logic [31:0]           stall_cnt;

   always_comb begin
      lat_eff  = (sb.issue_lat == '0) ? CW'(1) : sb.issue_lat;
      waw      = sb.issue_wr && (sb.issue_rd != '0) && (cnt[sb.issue_rd] > lat_eff);
      opnd_haz = 1'b0;
      fwd_en   = '0;
      fwd_data = '0;
      rs       = '0;
      for (int unsigned i = 0; i < NREAD; i++) begin
         rs = sb.rs_addr[i*RW +: RW];
         if (sb.rs_valid[i] && (rs != '0)) begin
            // A matching completion both forwards and satisfies the pending count.
            if (sb.res_valid && (sb.res_rd == rs)) begin
               fwd_en[i]                 = 1'b1;
               fwd_data[i*XLEN +: XLEN]  = sb.res_data;
            end else begin
               if (sb.wb_valid && (sb.wb_rd == rs)) begin
                  fwd_en[i]                = 1'b1;
                  fwd_data[i*XLEN +: XLEN] = sb.wb_data;
               end
               if (cnt[rs] != '0)
                  opnd_haz = 1'b1;
            end
         end
      end
      stall = sb.issue_valid && !sb.flush && (opnd_haz || waw);
      fire  = sb.issue_valid && !stall && !sb.flush && sb.issue_wr && (sb.issue_rd != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned r = 0; r < NREG; r++)
            cnt[r] <= '0;
         stall_cnt <= '0;
      end else begin
         if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 32'd1;
         // Issue load outranks a same-cycle completion: the new producer is younger.
         for (int unsigned r = 1; r < NREG; r++) begin
            if (sb.flush)
               cnt[r] <= '0;
            else if (fire && (sb.issue_rd == RW'(r)))
               cnt[r] <= lat_eff;
            else if (sb.res_valid && (sb.res_rd == RW'(r)))
               cnt[r] <= '0;
            else if (cnt[r] != '0)
               cnt[r] <= cnt[r] - CW'(1);
         end
      end
   end

   assign sb.stall        = stall;
   assign sb.fwd_en       = fwd_en;
   assign sb.fwd_data     = fwd_data;
   assign sb.stall_cycles = stall_cnt;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scoreboard bench for fwd_scoreboard: driver pushes model predictions, monitor pops and compares.
// Model tracks each register's absolute due cycle rather than a countdown.
module tb_fwd_scoreboard;
   localparam int XLEN = 32, NREG = 32, NREAD = 2, MAXLAT = 7;

   logic clk, rst;
   int   n_checks, n_err;

   fwd_scoreboard_if #(.XLEN(XLEN), .NREG(NREG), .NREAD(NREAD), .MAXLAT(MAXLAT)) bus ();
   fwd_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NREAD(NREAD), .MAXLAT(MAXLAT)) dut (
      .clk (clk),
      .rst (rst),
      .sb  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit iv, iw; int rd, lat; int rs0, rs1; bit v0, v1;
      bit rv; int rrd; logic [31:0] rdat;
      bit wv; int wrd; logic [31:0] wdat; bit fl;
   } stim_t;

   typedef struct {
      bit st; bit [1:0] en; logic [31:0] d0, d1; logic [31:0] sc;
   } exp_t;

   exp_t   q[$];
   longint cyc;
   longint due [NREG];
   longint sc_m;

   function automatic stim_t idle();
      stim_t s;
      s = '{default: 0};
      return s;
   endfunction

   function automatic longint remaining(int r);
      if (r == 0) return 0;
      return (due[r] > cyc) ? due[r] - cyc : 0;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < NREG; r++) due[r] = 0;
      sc_m = 0;
   endtask

   task automatic drive(input stim_t s);
      exp_t e;
      bit   haz, waw, fire;
      int   rsv [2];
      bit   vv  [2];
      logic [31:0] dd [2];
      @(negedge clk);
      bus.flush       = s.fl;
      bus.issue_valid = s.iv;
      bus.issue_wr    = s.iw;
      bus.issue_rd    = 5'(s.rd);
      bus.issue_lat   = 3'(s.lat);
      bus.rs_addr     = {5'(s.rs1), 5'(s.rs0)};
      bus.rs_valid    = {s.v1, s.v0};
      bus.res_valid   = s.rv;
      bus.res_rd      = 5'(s.rrd);
      bus.res_data    = s.rdat;
      bus.wb_valid    = s.wv;
      bus.wb_rd       = 5'(s.wrd);
      bus.wb_data     = s.wdat;

      rsv[0] = s.rs0; rsv[1] = s.rs1; vv[0] = s.v0; vv[1] = s.v1;
      haz = 0;
      e.en = '0;
      for (int i = 0; i < 2; i++) begin
         dd[i] = 'x;
         if (vv[i] && rsv[i] != 0) begin
            if (s.rv && s.rrd == rsv[i]) begin e.en[i] = 1; dd[i] = s.rdat; end
            else if (s.wv && s.wrd == rsv[i]) begin e.en[i] = 1; dd[i] = s.wdat; end
            if (remaining(rsv[i]) != 0 && !(s.rv && s.rrd == rsv[i])) haz = 1;
         end
      end
      waw  = s.iw && s.rd != 0 && remaining(s.rd) > s.lat;
      e.st = s.iv && !s.fl && (haz || waw);
      e.d0 = dd[0]; e.d1 = dd[1];
      e.sc = 32'(sc_m);
      q.push_back(e);

      fire = s.iv && !e.st && !s.fl && s.iw && s.rd != 0;
      if (s.fl) begin
         for (int r = 0; r < NREG; r++) due[r] = 0;
      end else begin
         if (s.rv && s.rrd != 0) due[s.rrd] = 0;
         if (fire) due[s.rd] = cyc + 1 + s.lat;
      end
      if (e.st) sc_m = (sc_m >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : sc_m + 1;
      cyc++;
   endtask

   // Monitor: outputs are combinational, so each driven cycle presents one observation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() != 0) begin
            e = q.pop_front();
            check("stall", {31'b0, bus.stall}, {31'b0, e.st});
            check("fwd_en", {30'b0, bus.fwd_en}, {30'b0, e.en});
            if (e.en[0]) check("fwd_data0", bus.fwd_data[31:0], e.d0);
            if (e.en[1]) check("fwd_data1", bus.fwd_data[63:32], e.d1);
            check("stall_cycles", bus.stall_cycles, e.sc);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      stim_t s;
      n_checks = 0; n_err = 0; cyc = 0;
      model_reset();
      rst = 1'b1;
      bus.flush = 0; bus.issue_valid = 0; bus.issue_wr = 0; bus.issue_rd = '0;
      bus.issue_lat = '0; bus.rs_addr = '0; bus.rs_valid = '0; bus.res_valid = 0;
      bus.res_rd = '0; bus.res_data = '0; bus.wb_valid = 0; bus.wb_rd = '0; bus.wb_data = '0;
      @(negedge clk);
      #1;
      check("reset_stall", {31'b0, bus.stall}, 32'd0);
      check("reset_fwd_en", {30'b0, bus.fwd_en}, 32'd0);
      check("reset_stall_cycles", bus.stall_cycles, 32'd0);
      rst = 1'b0;

      // x5 lat 1, then consumer forwarded from completion bus
      s = idle(); s.iv = 1; s.iw = 1; s.rd = 5; s.lat = 1; drive(s);
      s = idle(); s.iv = 1; s.rs0 = 5; s.v0 = 1; s.rv = 1; s.rrd = 5; s.rdat = 32'hDEADBEEF; drive(s);

      // x7 lat 3: two stalled cycles then forwarded completion
      s = idle(); s.iv = 1; s.iw = 1; s.rd = 7; s.lat = 3; drive(s);
      s = idle(); s.iv = 1; s.rs0 = 7; s.v0 = 1; drive(s);
      drive(s);
      s.rv = 1; s.rrd = 7; s.rdat = 32'h12; drive(s);

      // completion beats writeback; register 0 never forwards
      s = idle(); s.rs1 = 9; s.v1 = 1; s.rv = 1; s.rrd = 9; s.rdat = 32'hA;
      s.wv = 1; s.wrd = 9; s.wdat = 32'hB; drive(s);
      s.rs0 = 0; s.rs1 = 0; s.v0 = 1; s.rrd = 0; s.wrd = 0; drive(s);

      // WAW: x3 lat 5 pending, reissue with lat 1 until accepted
      s = idle(); s.iv = 1; s.iw = 1; s.rd = 3; s.lat = 5; drive(s);
      s.lat = 1;
      repeat (6) drive(s);

      // flush drops x4 and blocks the same-cycle issue of x6
      s = idle(); s.iv = 1; s.iw = 1; s.rd = 4; s.lat = 5; drive(s);
      s = idle(); s.fl = 1; s.iv = 1; s.iw = 1; s.rd = 6; s.lat = 3; drive(s);
      s = idle(); s.iv = 1; s.rs0 = 4; s.v0 = 1; s.rs1 = 6; s.v1 = 1; drive(s);

      // randomized traffic on a small register window to provoke hazards
      for (int n = 0; n < 2000; n++) begin
         s = idle();
         s.iv   = ($urandom_range(0, 99) < 70);
         s.iw   = ($urandom_range(0, 99) < 75);
         s.rd   = $urandom_range(0, 7);
         s.lat  = $urandom_range(1, MAXLAT);
         s.rs0  = $urandom_range(0, 7);
         s.rs1  = $urandom_range(0, 7);
         s.v0   = $urandom_range(0, 1);
         s.v1   = $urandom_range(0, 1);
         s.rv   = ($urandom_range(0, 99) < 40);
         s.rrd  = $urandom_range(0, 7);
         s.rdat = $urandom;
         s.wv   = ($urandom_range(0, 99) < 40);
         s.wrd  = $urandom_range(0, 7);
         s.wdat = $urandom;
         s.fl   = ($urandom_range(0, 99) < 3);
         drive(s);
      end

      // saturation: preload the counter near its ceiling, then stall on x2
      s = idle(); s.fl = 1; drive(s);
      s = idle(); s.iv = 1; s.iw = 1; s.rd = 2; s.lat = 7; drive(s);
      @(posedge clk);
      #1;
      force dut.stall_cnt = 32'hFFFF_FFFC;
      #1;
      release dut.stall_cnt;
      sc_m = 64'hFFFF_FFFC;
      s = idle(); s.iv = 1; s.rs0 = 2; s.v0 = 1;
      repeat (6) drive(s);

      // asynchronous reset while x2 is still pending and stall is high
      #3;
      rst = 1'b1;
      #1;
      check("async_rst_stall", {31'b0, bus.stall}, 32'd0);
      check("async_rst_stall_cycles", bus.stall_cycles, 32'd0);
      rst = 1'b0;
      model_reset();
      drive(s);
      s = idle(); s.iv = 1; s.iw = 1; s.rd = 2; s.lat = 1; drive(s);
      s = idle(); s.iv = 1; s.rs0 = 2; s.v0 = 1; s.rv = 1; s.rrd = 2; s.rdat = 32'h5A5A_0001; drive(s);

      for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
      #4;
      if (q.size() != 0) begin
         n_checks++;
         n_err++;
         $display("FAIL drain: %0d observations left, required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
